tensor_deserializer: RTL and testbench
======================================

# tensor_deserializer

Streaming-to-flat front-end for the pooling/activation stages. It accepts one signed fixed-point element per beat on a valid/ready stream and packs a full CH×IN_H×IN_W tensor into a flat vector. It presents that vector with a valid/ready handshake to a combinational consumer such as the max-pool stage. It also checks frame length against the stream's last flag.

## Interface
Parameters:
- CH, 1, channel count
- IN_H, 2, tensor height
- IN_W, 2, tensor width
- WIDTH, 16, element width in bits (signed)
- precision, "Q8.8", fixed-point format tag; informational, no arithmetic depends on it

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input element valid
- s_ready  out  1  block can accept an element
- s_data  in  WIDTH  signed element
- s_last  in  1  marks the final element of a frame
- m_valid  out  1  packed tensor valid
- m_ready  in  1  consumer accepts the tensor
- m_vec  out  CH*IN_H*IN_W*WIDTH  packed tensor
- err_len  out  1  one-cycle pulse on a frame-length error

## Operation
- N = CH*IN_H*IN_W. The element counter cnt has width clog2(N), minimum 1.
- Input order is channel-major, then row, then column. Beat k lands in m_vec[k*WIDTH +: WIDTH], where k = (c*IN_H+h)*IN_W+w. This matches the downstream flat indexing.
- A beat is accepted when s_valid && s_ready. A tensor is taken when m_valid && m_ready.
- State machine, with two states:
  - FILL: s_ready=1, m_valid=0. Each accepted beat writes slot cnt.
    - Beat with cnt<N-1 and s_last=0: cnt increments.
    - Beat with cnt<N-1 and s_last=1 (early last): err_len pulses, cnt returns to 0, the partial frame is discarded, and the state stays FILL.
    - Beat with cnt==N-1: the state moves to FULL and cnt returns to 0. If s_last=0 on this beat (missing last), err_len also pulses, but the frame is still delivered.
  - FULL: s_ready=0, m_valid=1. m_vec is held stable. On m_ready the state moves to FILL.
- No pass-through: s_ready is 0 for the whole FULL cycle, including the cycle in which m_ready is sampled high.
- Data is not modified. No saturation or sign handling is applied beyond storage.
- Unwritten slots of a discarded frame keep stale data. They are never presented, because m_valid only rises after all N slots have been written.

## Timing
- Reset (asynchronous, while rst is high):
  - state=FILL, cnt=0, m_vec=0, m_valid=0, err_len=0
  - s_ready=1, since it is decoded from state
  - Beats presented while rst is high are ignored.
- Latency: if the N-th beat is accepted at edge t, m_valid is high from just after t.
- m_valid falls on the edge where m_ready is sampled high. s_ready rises on that same edge.
- Minimum frame period is N+1 cycles.
- err_len is registered. It is high for exactly the cycle after the offending beat's edge.
- s_valid gaps are allowed anywhere in a frame. cnt holds during gaps.
- m_ready may be held high before m_valid rises. The tensor is then consumed one cycle after m_valid rises.
- Reset asserted mid-FILL or in FULL drops all frame state immediately. No partial output appears after reset.

## Structure
- The shared package nn_stream_pkg holds:
  - the state typedef: FILL, FULL
  - a clog2-based counter-width helper, reused by future streaming stages
- No sub-module. The block is a single FSM plus a counter and the storage register.

## Test plan
- Normal frame, CH=1, IN_H=2, IN_W=2, WIDTH=16:
  - Stimulus: beats 0x0100, 0xFF00, 0x0080, 0x7FFF, with s_last on the 4th beat.
  - Response: m_vec = 0x7FFF_0080_FF00_0100, m_valid high in the cycle after the 4th beat, err_len stays 0.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid rises.
  - Response: m_valid stays 1, m_vec is unchanged, s_ready=0.
  - Then raise m_ready for 1 cycle: m_valid=0 and s_ready=1 on the next cycle.
- Early last: s_last on beat 2.
  - Response: err_len pulses 1 cycle, no m_valid.
  - The following 4 beats 1, 2, 3, 4 with last give m_vec = 0x0004_0003_0002_0001.
- Missing last: 4 beats with s_last=0 throughout.
  - Response: err_len pulses in the cycle after beat 4, the frame is still delivered with m_valid=1.
- Reset mid-operation:
  - Accept 2 beats, then pulse rst asynchronously (not on a clock edge): m_valid=0, m_vec=0, s_ready=1.
  - Then 4 fresh beats produce exactly one correct frame.
- Bubbles: CH=2, IN_H=IN_W=2, with random s_valid gaps and 8 beats 0..7.
  - Response: slot k holds value k, and m_valid rises only after the 8th beat.

Source files
------------

// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared types and helpers for streaming NN front-end stages
//   Provides the FILL/FULL frame state and a counter-width helper.
package nn_stream_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // Width of a counter that indexes n slots; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tensor_deserializer_if.sv
// rtl/tensor_deserializer_if.sv - element stream in, packed tensor out
//   s_valid/s_ready/s_data/s_last : element stream (producer -> block)
//   m_valid/m_ready/m_vec         : packed tensor (block -> consumer)
//   slave modport is the block side, master modport is the environment side.
interface tensor_deserializer_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [N*WIDTH-1:0]      m_vec;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_vec
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_vec
  );
endinterface

// File: rtl/tensor_deserializer.sv
// rtl/tensor_deserializer.sv - packs a CH x IN_H x IN_W element stream into a flat tensor
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : tensor_deserializer_if.slave (element stream in, packed tensor out)
//   err_len : one-cycle pulse when a frame's length disagrees with s_last
module tensor_deserializer
  import nn_stream_pkg::*;
#(
  parameter int CH        = 1,
  parameter int IN_H      = 2,
  parameter int IN_W      = 2,
  parameter int WIDTH     = 16,
  parameter     precision = "Q8.8"
) (
  input  logic                 clk,
  input  logic                 rst,
  tensor_deserializer_if.slave bus,
  output logic                 err_len
);

  localparam int N  = CH * IN_H * IN_W;
  localparam int CW = cnt_width(N);
  localparam int VW = N * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // The fixed-point format tag only documents the data; nothing depends on it.
  if (precision == 0) begin : g_untagged
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            err_q, err_d;
  logic            beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = 1'b0;
    beat    = bus.s_valid && (state_q == FILL);

    if (state_q == FILL) begin
      if (beat) begin
        // Slots of a frame later discarded keep stale data; they are never
        // presented because FULL is only reached after all N writes.
        vec_d[int'(cnt_q)*WIDTH +: WIDTH] = bus.s_data;
        if (cnt_q == CNT_LAST) begin
          state_d = FULL;
          cnt_d   = '0;
          err_d   = !bus.s_last;
        end else if (bus.s_last) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else begin
      if (bus.m_ready) begin
        state_d = FILL;
      end
    end
  end

  // No pass-through: s_ready stays low for the whole FULL cycle.
  assign bus.s_ready = (state_q == FILL);
  assign bus.m_valid = (state_q == FULL);
  assign bus.m_vec   = vec_q;
  assign err_len     = err_q;

endmodule

// File: tb/tb_tensor_deserializer.sv
// tb/tb_tensor_deserializer.sv - self-checking bench for tensor_deserializer
module tb_tensor_deserializer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tensor_deserializer_if #(.WIDTH(W), .N(4)) a_if ();
  tensor_deserializer_if #(.WIDTH(W), .N(8)) b_if ();
  logic err_a, err_b;

  tensor_deserializer #(.CH(1), .IN_H(2), .IN_W(2), .WIDTH(W)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave), .err_len(err_a)
  );
  tensor_deserializer #(.CH(2), .IN_H(2), .IN_W(2), .WIDTH(W)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave), .err_len(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted elements of the frame in progress, and the
  // frame the block should currently be presenting.
  logic [W-1:0] mq[$];
  int           sel;
  logic [127:0] exp_vec;
  logic         exp_valid;
  logic         exp_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_sready();
    return (sel == 0) ? a_if.s_ready : b_if.s_ready;
  endfunction
  function automatic logic get_mvalid();
    return (sel == 0) ? a_if.m_valid : b_if.m_valid;
  endfunction
  function automatic logic [127:0] get_mvec();
    return (sel == 0) ? {64'h0, a_if.m_vec} : b_if.m_vec;
  endfunction
  function automatic logic get_err();
    return (sel == 0) ? err_a : err_b;
  endfunction

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic l);
    if (sel == 0) begin
      a_if.s_valid = v; a_if.s_data = d; a_if.s_last = l;
    end else begin
      b_if.s_valid = v; b_if.s_data = d; b_if.s_last = l;
    end
  endtask

  task automatic set_mready(input logic r);
    if (sel == 0) a_if.m_ready = r;
    else          b_if.m_ready = r;
  endtask

  // Frame rule: N collected elements make a frame (length error if that beat
  // lacks last); last arriving earlier is a length error and drops the frame.
  task automatic model_beat(input logic [W-1:0] d, input logic l);
    int n;
    n = (sel == 0) ? 4 : 8;
    mq.push_back(d);
    exp_err = 1'b0;
    if (mq.size() == n) begin
      exp_vec = '0;
      for (int k = 0; k < n; k++) exp_vec[k*W +: W] = mq[k];
      exp_valid = 1'b1;
      exp_err   = !l;
      mq.delete();
    end else if (l) begin
      exp_err = 1'b1;
      mq.delete();
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      set_in(1'b0, W'($urandom), 1'($urandom));
      tick();
      exp_err = 1'b0;
      chk("gap_m_valid", {127'h0, get_mvalid()}, {127'h0, exp_valid});
      chk("gap_err_len", {127'h0, get_err()}, 128'h0);
    end
    set_in(1'b1, d, l);
    chk("s_ready_fill", {127'h0, get_sready()}, 128'h1);
    tick();
    set_in(1'b0, '0, 1'b0);
    model_beat(d, l);
    chk("err_len", {127'h0, get_err()}, {127'h0, exp_err});
    chk("m_valid", {127'h0, get_mvalid()}, {127'h0, exp_valid});
    if (exp_valid) chk("m_vec", get_mvec(), exp_vec);
  endtask

  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_m_valid", {127'h0, get_mvalid()}, 128'h1);
      chk("hold_m_vec", get_mvec(), exp_vec);
      chk("hold_s_ready", {127'h0, get_sready()}, 128'h0);
      chk("hold_err_len", {127'h0, get_err()}, 128'h0);
    end
    set_mready(1'b1);
    chk("take_s_ready", {127'h0, get_sready()}, 128'h0);
    chk("take_m_valid", {127'h0, get_mvalid()}, 128'h1);
    tick();
    set_mready(1'b0);
    exp_valid = 1'b0;
    chk("after_m_valid", {127'h0, get_mvalid()}, 128'h0);
    chk("after_s_ready", {127'h0, get_sready()}, 128'h1);
    chk("after_err_len", {127'h0, get_err()}, 128'h0);
  endtask

  initial begin
    logic [W-1:0] rv;
    rst = 1'b1;
    sel = 0;
    exp_vec = '0; exp_valid = 1'b0; exp_err = 1'b0;
    a_if.s_valid = 0; a_if.s_data = '0; a_if.s_last = 0; a_if.m_ready = 0;
    b_if.s_valid = 0; b_if.s_data = '0; b_if.s_last = 0; b_if.m_ready = 0;

    #12;
    chk("rst_a_s_ready", {127'h0, a_if.s_ready}, 128'h1);
    chk("rst_a_m_valid", {127'h0, a_if.m_valid}, 128'h0);
    chk("rst_a_m_vec", {64'h0, a_if.m_vec}, 128'h0);
    chk("rst_a_err", {127'h0, err_a}, 128'h0);
    chk("rst_b_m_vec", b_if.m_vec, 128'h0);
    chk("rst_b_s_ready", {127'h0, b_if.s_ready}, 128'h1);
    #1 rst = 1'b0;

    // Normal frame, then 5 cycles of backpressure.
    send(16'h0100, 1'b0, 0);
    send(16'hFF00, 1'b0, 0);
    send(16'h0080, 1'b0, 0);
    send(16'h7FFF, 1'b1, 0);
    chk("normal_vec", get_mvec(), 128'h7FFF_0080_FF00_0100);
    consume(5);

    // Early last on beat 2, then a clean frame.
    send(16'h0011, 1'b0, 0);
    send(16'h0022, 1'b1, 0);
    send(16'h0001, 1'b0, 0);
    send(16'h0002, 1'b0, 0);
    send(16'h0003, 1'b0, 0);
    send(16'h0004, 1'b1, 0);
    chk("early_last_vec", get_mvec(), 128'h0004_0003_0002_0001);
    consume(0);

    // Missing last: error pulse but frame still delivered.
    send(16'hA001, 1'b0, 0);
    send(16'hA002, 1'b0, 0);
    send(16'hA003, 1'b0, 0);
    send(16'hA004, 1'b0, 0);
    chk("missing_last_err", {127'h0, get_err()}, 128'h1);
    consume(1);

    // m_ready held high before the frame completes.
    set_mready(1'b1);
    for (int k = 0; k < 4; k++) send(W'(16'h0C00 + k), k == 3, 0);
    tick();
    set_mready(1'b0);
    exp_valid = 1'b0;
    chk("early_ready_m_valid", {127'h0, get_mvalid()}, 128'h0);
    chk("early_ready_s_ready", {127'h0, get_sready()}, 128'h1);

    // Randomized frames with bubbles and random hold times.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) begin
        rv = W'($urandom);
        send(rv, (k == 3) ? 1'b1 : 1'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      end
      if (exp_valid) consume($urandom_range(0, 3));
    end
    // Drain any partial frame so the next test starts clean.
    while (mq.size() != 0) send(W'($urandom), 1'b1, 0);
    if (exp_valid) consume(0);

    // Asynchronous reset mid-fill; beats during reset are ignored.
    send(16'h1111, 1'b0, 0);
    send(16'h2222, 1'b0, 0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_m_valid", {127'h0, get_mvalid()}, 128'h0);
    chk("midrst_m_vec", get_mvec(), 128'h0);
    chk("midrst_s_ready", {127'h0, get_sready()}, 128'h1);
    set_in(1'b1, 16'hBEEF, 1'b1);
    tick();
    chk("rst_beat_err", {127'h0, get_err()}, 128'h0);
    chk("rst_beat_m_vec", get_mvec(), 128'h0);
    set_in(1'b0, '0, 1'b0);
    #3 rst = 1'b0;
    mq.delete();
    exp_valid = 1'b0;
    send(16'h0005, 1'b0, 0);
    send(16'h0006, 1'b0, 0);
    send(16'h0007, 1'b0, 0);
    send(16'h0008, 1'b1, 0);
    chk("post_rst_vec", get_mvec(), 128'h0008_0007_0006_0005);
    consume(0);

    // Larger tensor with random bubbles: slot k holds k.
    sel = 1;
    for (int k = 0; k < 8; k++) send(W'(k), k == 7, $urandom_range(0, 3));
    for (int k = 0; k < 8; k++) chk("bubble_slot", {112'h0, b_if.m_vec[k*W +: W]}, 128'(k));
    consume(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
